// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the machine-level interrupt controller:
// register word offsets, ctrl bit positions, claim encoding and the
// bus byte-order helper used by both the top level and the timer.
package irq_ctrl_pkg;

    // Word offsets, i.e. the value of a[4:2]
    localparam logic [2:0] IRQ_MTIME_LO    = 3'd0;
    localparam logic [2:0] IRQ_MTIME_HI    = 3'd1;
    localparam logic [2:0] IRQ_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] IRQ_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] IRQ_PENDING     = 3'd4;
    localparam logic [2:0] IRQ_ENABLE      = 3'd5;
    localparam logic [2:0] IRQ_CLAIM       = 3'd6;
    localparam logic [2:0] IRQ_CTRL        = 3'd7;

    // Bit positions inside the ctrl register
    localparam int CTRL_TIMER_EN  = 0;
    localparam int CTRL_MTIME_RUN = 1;

    // Claim value meaning "nothing acknowledged yet"
    localparam logic [4:0] CLAIM_NONE = 5'd0;

    // Which interrupt, if any, the output stage is presenting to the core
    typedef enum logic [1:0] {
        KIND_NONE  = 2'd0,
        KIND_TIMER = 2'd1,
        KIND_SRC   = 2'd2
    } irq_kind_e;

    // The bus carries words with their bytes reversed relative to the
    // register value; the same swap converts in both directions.
    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/irq_ctrl_timer.sv
// irq_timer: 64-bit mtime counter with prescaler, 64-bit mtimecmp and the
// registered timer_pend comparison. Word writes arrive already converted
// to register byte order; a write to an mtime half overrides the
// increment happening in the same cycle.
module irq_timer
    import irq_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        wr_mtime_lo,
    input  logic        wr_mtime_hi,
    input  logic        wr_cmp_lo,
    input  logic        wr_cmp_hi,
    input  logic [31:0] wr_data,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        timer_pend
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic [63:0]   mtime_inc;

    // A tick happens on the prescaler wrap while the timer is running
    always_comb begin
        tick      = run && (presc == PRESC_LAST);
        mtime_inc = tick ? (mtime + 64'd1) : mtime;
    end

    // Prescaler, mtime, mtimecmp and the one-cycle-late compare flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc      <= '0;
            mtime      <= '0;
            mtimecmp   <= '1;
            timer_pend <= 1'b0;
        end else begin
            if (run) begin
                presc <= tick ? '0 : (presc + PW'(1));
            end
            mtime[31:0]  <= wr_mtime_lo ? wr_data : mtime_inc[31:0];
            mtime[63:32] <= wr_mtime_hi ? wr_data : mtime_inc[63:32];
            if (wr_cmp_lo) begin
                mtimecmp[31:0] <= wr_data;
            end
            if (wr_cmp_hi) begin
                mtimecmp[63:32] <= wr_data;
            end
            timer_pend <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-level interrupt controller in front of the RV32 core.
// Latches rising edges on N_SRC external sources, masks them with enable,
// and presents either the timer or the lowest-numbered enabled source on
// eip/eip_istimer. Software reaches it through a small word-mapped slave.
// Build option: define IRQ_SYNC_EN to pass every irq_src bit through a
// two-flop synchronizer ahead of the edge detector.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC    = 4,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic [4:0]       a,
    input  logic [31:0]      d,
    input  logic             we,
    input  logic             rd,
    output logic [31:0]      spo,
    output logic             ready,
    input  logic [N_SRC-1:0] irq_src,
    output logic             eip,
    output logic             eip_istimer,
    input  logic             eip_reply
);

    logic             wr_en;
    logic             rd_en;
    logic [2:0]       word;
    logic [31:0]      wr_val;
    logic [31:0]      rd_val;

    logic [N_SRC-1:0] src_s;
    logic [N_SRC-1:0] src_prev;
    logic [N_SRC-1:0] src_edge;

    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] enable;
    logic [1:0]       ctrl;
    logic [4:0]       claim;
    logic [3:0]       sel;

    logic [N_SRC-1:0] w1c_mask;
    logic [N_SRC-1:0] reply_mask;
    logic             reply_ack;
    logic [N_SRC-1:0] pending_next;
    logic [N_SRC-1:0] enable_next;
    logic [1:0]       ctrl_next;
    logic [N_SRC-1:0] active;
    logic [3:0]       sel_next;
    irq_kind_e        kind_next;

    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic             timer_pend;

    logic             unused_addr_bits;

    assign wr_en  = cs & we;
    assign rd_en  = cs & rd & ~we;
    assign word   = a[4:2];
    assign wr_val = bswap32(d);
    assign ready  = ~rd_en;
    assign unused_addr_bits = ^a[1:0];

    irq_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .run         (ctrl[CTRL_MTIME_RUN]),
        .wr_mtime_lo (wr_en && (word == IRQ_MTIME_LO)),
        .wr_mtime_hi (wr_en && (word == IRQ_MTIME_HI)),
        .wr_cmp_lo   (wr_en && (word == IRQ_MTIMECMP_LO)),
        .wr_cmp_hi   (wr_en && (word == IRQ_MTIMECMP_HI)),
        .wr_data     (wr_val),
        .mtime       (mtime),
        .mtimecmp    (mtimecmp),
        .timer_pend  (timer_pend)
    );

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;

    // Two-flop synchronizer for sources that are asynchronous to clk
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
        end
    end

    assign src_s = sync2;
`else
    assign src_s = irq_src;
`endif

    // Previous source sample, the reference for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            src_prev <= '0;
        end else begin
            src_prev <= src_s;
        end
    end

    // Next-state of the software-visible registers; a new edge beats any clear
    always_comb begin
        src_edge     = src_s & ~src_prev;
        w1c_mask     = (wr_en && (word == IRQ_PENDING)) ? wr_val[N_SRC-1:0] : '0;
        reply_ack    = eip_reply & eip & ~eip_istimer;
        reply_mask   = reply_ack ? (N_SRC'(1) << sel) : '0;
        pending_next = (pending & ~w1c_mask & ~reply_mask) | src_edge;
        enable_next  = (wr_en && (word == IRQ_ENABLE)) ? wr_val[N_SRC-1:0] : enable;
        ctrl_next    = (wr_en && (word == IRQ_CTRL)) ? wr_val[1:0] : ctrl;
    end

    // Priority pick: timer first, then the lowest enabled pending source
    always_comb begin
        active   = pending_next & enable_next;
        sel_next = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel_next = 4'(i);
            end
        end
        if (ctrl_next[CTRL_TIMER_EN] && timer_pend) begin
            kind_next = KIND_TIMER;
        end else if (|active) begin
            kind_next = KIND_SRC;
        end else begin
            kind_next = KIND_NONE;
        end
    end

    // Control/status registers plus the registered interrupt outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending     <= '0;
            enable      <= '0;
            ctrl        <= '0;
            claim       <= CLAIM_NONE;
            sel         <= '0;
            eip         <= 1'b0;
            eip_istimer <= 1'b0;
        end else begin
            pending     <= pending_next;
            enable      <= enable_next;
            ctrl        <= ctrl_next;
            if (reply_ack) begin
                claim <= 5'(sel) + 5'd1;
            end
            sel         <= sel_next;
            eip         <= (kind_next != KIND_NONE);
            eip_istimer <= (kind_next == KIND_TIMER);
        end
    end

    // Read multiplexer in register byte order; unused bits stay zero
    always_comb begin
        rd_val = '0;
        case (word)
            IRQ_MTIME_LO:    rd_val = mtime[31:0];
            IRQ_MTIME_HI:    rd_val = mtime[63:32];
            IRQ_MTIMECMP_LO: rd_val = mtimecmp[31:0];
            IRQ_MTIMECMP_HI: rd_val = mtimecmp[63:32];
            IRQ_PENDING:     rd_val[N_SRC-1:0] = pending;
            IRQ_ENABLE:      rd_val[N_SRC-1:0] = enable;
            IRQ_CLAIM:       rd_val[4:0] = claim;
            IRQ_CTRL:        rd_val[1:0] = ctrl;
            default:         rd_val = '0;
        endcase
    end

    // Read data is captured at the end of the wait cycle and held until the next read
    always_ff @(posedge clk) begin
        if (!rst) begin
            spo <= '0;
        end else if (rd_en) begin
            spo <= bswap32(rd_val);
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl (N_SRC=4, TICK_DIV=1). A behavioural
// model of pending/enable/claim and of the timer value lives here and
// is driven by randomized source pulses, enables and timer values.
module tb_irq_ctrl;

    localparam int N_SRC = 4;

    localparam logic [4:0] A_MTIME_LO = 5'h00;
    localparam logic [4:0] A_MTIME_HI = 5'h04;
    localparam logic [4:0] A_CMP_LO   = 5'h08;
    localparam logic [4:0] A_CMP_HI   = 5'h0C;
    localparam logic [4:0] A_PENDING  = 5'h10;
    localparam logic [4:0] A_ENABLE   = 5'h14;
    localparam logic [4:0] A_CLAIM    = 5'h18;
    localparam logic [4:0] A_CTRL     = 5'h1C;

    logic             clk;
    logic             rst;
    logic             cs;
    logic [4:0]       a;
    logic [31:0]      d;
    logic             we;
    logic             rd;
    logic [31:0]      spo;
    logic             ready;
    logic [N_SRC-1:0] irq_src;
    logic             eip;
    logic             eip_istimer;
    logic             eip_reply;

    int n_checks;
    int n_fail;

    irq_ctrl #(
        .N_SRC    (N_SRC),
        .TICK_DIV (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cs          (cs),
        .a           (a),
        .d           (d),
        .we          (we),
        .rd          (rd),
        .spo         (spo),
        .ready       (ready),
        .irq_src     (irq_src),
        .eip         (eip),
        .eip_istimer (eip_istimer),
        .eip_reply   (eip_reply)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] swap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [31:0] val);
        cs = 1'b1; we = 1'b1; rd = 1'b0; a = addr; d = swap(val);
        tick();
        cs = 1'b0; we = 1'b0; d = '0;
    endtask

    task automatic bus_read(input logic [4:0] addr, output logic [31:0] val,
                            output logic rdy_wait, output logic rdy_done);
        cs = 1'b1; rd = 1'b1; we = 1'b0; a = addr;
        #1;
        rdy_wait = ready;
        tick();
        cs = 1'b0; rd = 1'b0;
        #1;
        rdy_done = ready;
        val = swap(spo);
    endtask

    task automatic pulse_src(input logic [N_SRC-1:0] mask);
        irq_src = mask;
        repeat (2) tick();
        irq_src = '0;
        repeat (4) tick();
    endtask

    task automatic pulse_reply();
        eip_reply = 1'b1;
        tick();
        eip_reply = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic rw, rdn;
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (ready !== 1'b1 || spo !== 32'h0 || eip !== 1'b0 || eip_istimer !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got ready=%b spo=%h eip=%b ist=%b expected 1/0/0/0",
                     ready, spo, eip, eip_istimer);
        end
        bus_read(A_CMP_LO, v, rw, rdn);
        n_checks++;
        if (v !== 32'hFFFF_FFFF || rw !== 1'b0 || rdn !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_cmp_lo: got %h ready %b/%b expected ffffffff ready 0/1", v, rw, rdn);
        end
        bus_read(A_CMP_HI, v, rw, rdn);
        n_checks++;
        if (v !== 32'hFFFF_FFFF || rw !== 1'b0 || rdn !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_cmp_hi: got %h ready %b/%b expected ffffffff ready 0/1", v, rw, rdn);
        end
    endtask

    task automatic test_timer_irq();
        logic [31:0] v;
        logic rw, rdn;
        logic found;
        bus_write(A_CMP_HI, 32'h0);
        bus_write(A_CMP_LO, 32'd5);
        bus_write(A_CTRL, 32'h3);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (eip === 1'b1 && eip_istimer === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL timer_eip_raise: got eip=%b ist=%b expected 1/1 within budget", eip, eip_istimer);
        end
        pulse_reply();
        n_checks++;
        if (eip !== 1'b1 || eip_istimer !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL timer_reply_keeps: got eip=%b ist=%b expected 1/1", eip, eip_istimer);
        end
        bus_read(A_CLAIM, v, rw, rdn);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL timer_reply_claim: got %h expected 00000000", v);
        end
        bus_write(A_CMP_LO, 32'hFFFF_FFFF);
        found = 1'b0;
        for (int i = 0; i < 2 && !found; i++) begin
            tick();
            if (eip === 1'b0) found = 1'b1;
        end
        n_checks++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL timer_eip_clear: got eip=%b expected 0 within 2 cycles", eip);
        end
        bus_write(A_CTRL, 32'h0);
    endtask

    task automatic test_mtime();
        logic [31:0] lo, hi, clo, chi;
        logic rw, rdn;
        logic [63:0] start, expv, cmpv;
        int k;
        bus_write(A_CTRL, 32'h0);
        bus_write(A_MTIME_LO, 32'hFFFF_FFFF);
        bus_write(A_MTIME_HI, 32'hFFFF_FFFF);
        bus_write(A_CTRL, 32'h2);
        bus_write(A_CTRL, 32'h0);
        bus_read(A_MTIME_LO, lo, rw, rdn);
        bus_read(A_MTIME_HI, hi, rw, rdn);
        n_checks++;
        if ({hi, lo} !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL mtime_wrap: got %h expected 0000000000000000", {hi, lo});
        end
        for (int it = 0; it < 4; it++) begin
            start = {$urandom, $urandom};
            if (it == 0) start[31:0] = 32'hFFFF_FFF8;
            k = $urandom_range(1, 20);
            expv = start + 64'(k);
            cmpv = {$urandom, $urandom};
            bus_write(A_MTIME_LO, start[31:0]);
            bus_write(A_MTIME_HI, start[63:32]);
            bus_write(A_CMP_LO, cmpv[31:0]);
            bus_write(A_CMP_HI, cmpv[63:32]);
            bus_write(A_CTRL, 32'h2);
            repeat (k - 1) tick();
            bus_write(A_CTRL, 32'h0);
            bus_read(A_MTIME_LO, lo, rw, rdn);
            bus_read(A_MTIME_HI, hi, rw, rdn);
            n_checks++;
            if ({hi, lo} !== expv) begin
                n_fail++;
                $display("[TB] FAIL mtime_run_%0d: got %h expected %h", it, {hi, lo}, expv);
            end
            bus_read(A_CMP_LO, clo, rw, rdn);
            bus_read(A_CMP_HI, chi, rw, rdn);
            n_checks++;
            if ({chi, clo} !== cmpv) begin
                n_fail++;
                $display("[TB] FAIL mtimecmp_rw_%0d: got %h expected %h", it, {chi, clo}, cmpv);
            end
        end
    endtask

    task automatic test_sources_directed();
        logic [31:0] v;
        logic rw, rdn;
        bus_write(A_CTRL, 32'h0);
        bus_write(A_PENDING, 32'hF);
        bus_write(A_ENABLE, 32'h6);
        pulse_src(4'b0100);
        pulse_src(4'b0010);
        bus_read(A_PENDING, v, rw, rdn);
        n_checks++;
        if (v !== 32'h6 || eip !== 1'b1 || eip_istimer !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL src_pending: got pend=%h eip=%b ist=%b expected 6/1/0", v, eip, eip_istimer);
        end
        pulse_reply();
        bus_read(A_CLAIM, v, rw, rdn);
        n_checks++;
        if (v !== 32'd2) begin
            n_fail++;
            $display("[TB] FAIL src_claim_first: got %h expected 00000002", v);
        end
        bus_read(A_PENDING, v, rw, rdn);
        n_checks++;
        if (v !== 32'h4) begin
            n_fail++;
            $display("[TB] FAIL src_pending_after: got %h expected 00000004", v);
        end
        pulse_reply();
        bus_read(A_CLAIM, v, rw, rdn);
        n_checks++;
        if (v !== 32'd3 || eip !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL src_claim_second: got claim=%h eip=%b expected 3/0", v, eip);
        end
        pulse_reply();
        bus_read(A_CLAIM, v, rw, rdn);
        n_checks++;
        if (v !== 32'd3) begin
            n_fail++;
            $display("[TB] FAIL reply_idle_ignored: got %h expected 00000003", v);
        end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] v;
        logic rw, rdn;
        pulse_src(4'b0001);
        irq_src = 4'b0001;
        cs = 1'b1; we = 1'b1; a = A_PENDING; d = swap(32'h1);
        tick();
        cs = 1'b0; we = 1'b0; d = '0;
        repeat (4) tick();
        irq_src = '0;
        bus_read(A_PENDING, v, rw, rdn);
        n_checks++;
        if (v[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL w1c_set_wins: got pending=%h expected bit0=1", v);
        end
        bus_write(A_PENDING, 32'h1);
        bus_read(A_PENDING, v, rw, rdn);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL w1c_clear: got %h expected 00000000", v);
        end
    endtask

    task automatic test_sources_random();
        logic [31:0] v;
        logic rw, rdn;
        logic [N_SRC-1:0] pend_m, en_m, mask, act, clr;
        int claim_m, k, guard;
        pend_m  = '0;
        claim_m = 3;
        for (int it = 0; it < 8; it++) begin
            en_m = N_SRC'($urandom_range(0, 15));
            bus_write(A_ENABLE, 32'(en_m));
            mask = N_SRC'($urandom_range(0, 15));
            pulse_src(mask);
            pend_m = pend_m | mask;
            bus_read(A_PENDING, v, rw, rdn);
            n_checks++;
            if (v !== 32'(pend_m) || eip !== |(pend_m & en_m) || eip_istimer !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rand_pending_%0d: got pend=%h eip=%b expected pend=%h eip=%b",
                         it, v, eip, pend_m, |(pend_m & en_m));
            end
            guard = 0;
            while ((pend_m & en_m) != 0 && guard < 5) begin
                act = pend_m & en_m;
                k = 0;
                for (int j = N_SRC - 1; j >= 0; j--) if (act[j]) k = j;
                pulse_reply();
                pend_m[k] = 1'b0;
                claim_m = k + 1;
                bus_read(A_CLAIM, v, rw, rdn);
                n_checks++;
                if (v !== 32'(claim_m) || eip !== |(pend_m & en_m)) begin
                    n_fail++;
                    $display("[TB] FAIL rand_claim_%0d: got claim=%h eip=%b expected claim=%0d eip=%b",
                             it, v, eip, claim_m, |(pend_m & en_m));
                end
                guard++;
            end
            clr = N_SRC'($urandom_range(0, 15));
            bus_write(A_PENDING, 32'(clr));
            pend_m = pend_m & ~clr;
        end
        bus_read(A_PENDING, v, rw, rdn);
        n_checks++;
        if (v !== 32'(pend_m)) begin
            n_fail++;
            $display("[TB] FAIL rand_pending_final: got %h expected %h", v, pend_m);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] v;
        logic rw, rdn;
        logic [4:0]  addrs [8];
        logic [31:0] expv  [8];
        addrs = '{A_MTIME_LO, A_MTIME_HI, A_CMP_LO, A_CMP_HI, A_PENDING, A_ENABLE, A_CLAIM, A_CTRL};
        expv  = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        bus_write(A_ENABLE, 32'hF);
        bus_write(A_CTRL, 32'h3);
        pulse_src(4'b1000);
        cs = 1'b1; rd = 1'b1; we = 1'b0; a = A_ENABLE;
        #1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midread_wait: got ready=%b expected 0", ready);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1; cs = 1'b0; rd = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1 || spo !== 32'h0 || eip !== 1'b0 || eip_istimer !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midread_outputs: got ready=%b spo=%h eip=%b ist=%b expected 1/0/0/0",
                     ready, spo, eip, eip_istimer);
        end
        for (int i = 0; i < 8; i++) begin
            bus_read(addrs[i], v, rw, rdn);
            n_checks++;
            if (v !== expv[i]) begin
                n_fail++;
                $display("[TB] FAIL midread_reg_%h: got %h expected %h", addrs[i], v, expv[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clk = 1'b0; rst = 1'b0; cs = 1'b0; a = '0; d = '0;
        we = 1'b0; rd = 1'b0; irq_src = '0; eip_reply = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_timer_irq();
        test_mtime();
        test_sources_directed();
        test_w1c_collision();
        test_sources_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
